spi_wb_arbiter: RTL
===================

Name: spi_wb_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter in front of the SPI master core's register port.
- m0 is the APB software path; m1 is the XIP flash sequencer.
- Grants whole multi-step sequences (TX/DIVIDER/SS/CTRL/poll/RX) atomically via per-master lock.
- Adds a no-ack watchdog so a hung slave never stalls the CPU bus.

Parameters:
- RR_MODE, 1, 1 = round-robin on contention; 0 = fixed priority to m1.
- TIMEOUT_CYCLES, 1024, cycles of unacked s_stb before error; 0 disables the watchdog.
- TO_W, 16, width of the watchdog counter.

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- mN_adr_i  in  5  register address (N = 0, 1 for all mN_ ports)
- mN_dat_i  in  32  write data
- mN_sel_i  in  4  byte enables
- mN_we_i  in  1  write enable
- mN_stb_i  in  1  strobe
- mN_cyc_i  in  1  cycle
- mN_lock_i  in  1  hold grant after cyc drops
- mN_dat_o  out  32  read data (both driven from s_dat_i)
- mN_ack_o  out  1  acknowledge
- mN_err_o  out  1  error (slave err or timeout)
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o  out  5/32/4/1/1/1  to spi_top
- s_dat_i, s_ack_i, s_err_i  in  32/1/1  from spi_top
- grant_o  out  2  one-hot current owner ({m1,m0}); 00 = idle

Behaviour:
- Reset (asynchronous): state IDLE, owner cleared, last-granted pointer = m1, watchdog counter = 0.
- Reset output values: grant_o = 00; all s_* = 0; all mN_ack_o/mN_err_o = 0; mN_dat_o = s_dat_i.
- Request definition: reqN = mN_cyc_i & mN_stb_i.
- States: IDLE, OWN, TOERR.
- IDLE, arbitration:
  - Only one reqN high: grant that master.
  - Both high: if RR_MODE = 1, grant the master opposite the last-granted pointer; if RR_MODE = 0, grant m1.
  - Owner and pointer are registered; go to OWN.
  - Latency: a request first high in cycle N gives s_stb_o = 1 in cycle N+1.
- OWN:
  - s_* = owner's signals combinationally.
  - Owner gets s_ack_i/s_err_i; the non-owner gets ack = err = 0.
- OWN, release: when owner cyc = 0 and lock = 0 in the same cycle, go to IDLE next cycle.
  - A waiting master is granted at the earliest one cycle after that (one idle bubble is required).
- OWN, lock held:
  - Owner with cyc = 0 and lock = 1 keeps OWN.
  - s_cyc_o = s_stb_o = 0 while cyc = 0; the other master waits.
  - The non-owner's lock is ignored.
- Watchdog (TIMEOUT_CYCLES > 0):
  - Counter increments each OWN cycle with s_stb_o = 1 and s_ack_i = 0 and s_err_i = 0.
  - Cleared on ack, on err, or when s_stb_o = 0.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack: go to TOERR.
- TOERR (exactly one cycle):
  - Owner's err_o = 1; s_cyc_o = s_stb_o = 0; counter cleared.
  - Return to OWN; the lock/cyc release rule then applies normally.
- Simultaneous ack and timeout threshold in the same cycle: ack wins, no error.
- s_err_i passes straight through to the owner's err_o; no state change.
- Counter saturates rather than wrapping (irrelevant when TIMEOUT_CYCLES < 2^TO_W).
- Reset mid-transaction aborts immediately with all outputs at reset values.
  - Masters must restart their sequences; the SPI core is reset by the same signal.

Decomposition:
- Shared package spi_xip_pkg:
  - State encoding (IDLE/OWN/TOERR).
  - Master index constants M_SW = 0, M_XIP = 1.
  - SPI register offsets RX0 = 0x00, TX0 = 0x00, TX1 = 0x04, CTRL = 0x10, DIVIDER = 0x14, SS = 0x18.
  - CTRL bit positions GO_BSY = 8 and CHAR_LEN[6:0], used by both the XIP sequencer and the arbiter bench.
- One natural sub-module: spi_wb_watchdog (counter, threshold compare, timeout pulse).
  - Arbiter top holds arbitration FSM and muxes.

Test Plan:
- Single m0 write: m0 adr = 0x14, dat = 0x1 in cycle 0.
  - s_stb_o = 1 in cycle 1 with same adr/dat; ack from slave in cycle 2 appears on m0_ack_o in cycle 2.
  - m1_ack_o stays 0.
- Contention, RR_MODE = 1: both request in same cycle, pointer = m1 after reset.
  - m0 granted first; after m0 release, 1 idle cycle, then m1 granted (grant_o 01 -> 00 -> 10).
- Contention, RR_MODE = 0: both request.
  - m1 granted; a repeated m1 request after each release keeps beating m0.
- Lock: m1 does 6 back-to-back transactions with m1_lock_i = 1, cyc gaps of 2 cycles; m0 requests throughout.
  - grant_o stays 10 until m1_lock_i = 0 and m1_cyc_i = 0; m0 granted 2 cycles later.
- Timeout: TIMEOUT_CYCLES = 8, slave never acks.
  - m1_err_o = 1 exactly 8 cycles after s_stb_o rises; s_cyc_o = 0 that cycle; ack arriving on cycle 8 instead yields ack, no err.
- Reset mid-op: assert reset while m1 owns with lock.
  - All outputs 0 and grant_o = 00 asynchronously; after release, m0 request granted with 1-cycle latency.

Source files
------------

// File: rtl/spi_xip_pkg.sv
// Shared definitions for the SPI XIP slice: arbiter state encoding, master
// indices, SPI core register map and the Wishbone request payload.
package spi_xip_pkg;

    localparam int unsigned ADR_W = 5;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN   = 2'd1;
    localparam logic [1:0] ST_TOERR = 2'd2;

    localparam logic M_SW  = 1'b0;
    localparam logic M_XIP = 1'b1;

    localparam logic [ADR_W-1:0] REG_RX0     = 5'h00;
    localparam logic [ADR_W-1:0] REG_TX0     = 5'h00;
    localparam logic [ADR_W-1:0] REG_TX1     = 5'h04;
    localparam logic [ADR_W-1:0] REG_CTRL    = 5'h10;
    localparam logic [ADR_W-1:0] REG_DIVIDER = 5'h14;
    localparam logic [ADR_W-1:0] REG_SS      = 5'h18;

    localparam int unsigned CTRL_GO_BSY       = 8;
    localparam int unsigned CTRL_CHAR_LEN_MSB = 6;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
        logic             we;
        logic             stb;
        logic             cyc;
    } wb_req_t;

    // CTRL register value that starts a transfer of char_len bits
    function automatic logic [DAT_W-1:0] ctrl_word(input logic [6:0] char_len, input logic go);
        logic [DAT_W-1:0] w;
        w = '0;
        w[CTRL_CHAR_LEN_MSB:0] = char_len;
        w[CTRL_GO_BSY] = go;
        return w;
    endfunction

endpackage

// File: rtl/spi_wb_watchdog.sv
// No-ack watchdog: counts consecutive unanswered strobe cycles of the current
// owner and flags a timeout on the cycle the threshold is reached.
module spi_wb_watchdog
    import spi_xip_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic active_i,
    input  logic stb_i,
    input  logic ack_i,
    input  logic err_i,
    output logic timeout_c
);

    localparam logic [TO_W-1:0] THRESH  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};
    localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;
    logic            stall;

    // A response of either kind, or a dropped strobe, restarts the count
    always_comb begin
        stall     = active_i & stb_i & ~ack_i & ~err_i;
        cnt_d     = '0;
        timeout_c = 1'b0;
        if (stall && WD_EN) begin
            cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TO_W'(1);
            timeout_c = (cnt_q == THRESH);
        end
        if (timeout_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the SPI core register port, with
// per-master sequence lock and a no-ack watchdog.
module spi_wb_arbiter
    import spi_xip_pkg::*;
#(
    parameter int unsigned RR_MODE        = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic             m0_we_i,
    input  logic             m0_stb_i,
    input  logic             m0_cyc_i,
    input  logic             m0_lock_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic             m1_we_i,
    input  logic             m1_stb_i,
    input  logic             m1_cyc_i,
    input  logic             m1_lock_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic             s_we_o,
    output logic             s_stb_o,
    output logic             s_cyc_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    output logic [1:0]       grant_o
);

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;

    wb_req_t    req0, req1, own_req;
    logic       own_lock;
    logic       own_stb;
    logic       req_0, req_1;
    logic       pick;
    logic       wd_timeout_c;
    logic [1:0] ack_v, err_v;

    assign req0 = '{adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i, we: m0_we_i,
                    stb: m0_stb_i, cyc: m0_cyc_i};
    assign req1 = '{adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i, we: m1_we_i,
                    stb: m1_stb_i, cyc: m1_cyc_i};

    assign req_0    = m0_cyc_i & m0_stb_i;
    assign req_1    = m1_cyc_i & m1_stb_i;
    assign own_req  = owner_q ? req1 : req0;
    assign own_lock = owner_q ? m1_lock_i : m0_lock_i;
    // Strobe is only forwarded inside an open cycle
    assign own_stb  = own_req.stb & own_req.cyc;

    spi_wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .active_i  (state_q == ST_OWN),
        .stb_i     (own_stb),
        .ack_i     (s_ack_i),
        .err_i     (s_err_i),
        .timeout_c (wd_timeout_c)
    );

    // Arbitration, ownership and slave-side mux
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        pick    = M_SW;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        ack_v   = 2'b00;
        err_v   = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (req_0 || req_1) begin
                    if (req_0 && req_1) begin
                        pick = (RR_MODE != 0) ? ~last_q : M_XIP;
                    end else begin
                        pick = req_1;
                    end
                    owner_d = pick;
                    last_d  = pick;
                    state_d = ST_OWN;
                end
            end
            ST_OWN: begin
                s_adr_o        = own_req.adr;
                s_dat_o        = own_req.dat;
                s_sel_o        = own_req.sel;
                s_we_o         = own_req.we;
                s_cyc_o        = own_req.cyc;
                s_stb_o        = own_stb;
                ack_v[owner_q] = s_ack_i;
                err_v[owner_q] = s_err_i;
                if (wd_timeout_c) begin
                    state_d = ST_TOERR;
                end else if (!own_req.cyc && !own_lock) begin
                    state_d = ST_IDLE;
                end
            end
            ST_TOERR: begin
                err_v[owner_q] = 1'b1;
                state_d        = ST_OWN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant_o  = (state_q == ST_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    assign m0_ack_o = ack_v[0];
    assign m1_ack_o = ack_v[1];
    assign m0_err_o = err_v[0];
    assign m1_err_o = err_v[1];
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= M_SW;
            last_q  <= M_XIP;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

endmodule
